// File: rtl/frame_sample_buffer.sv
// Multi-channel sample frame buffer: NCH parallel RAMs filled per strobe, hold or circular mode, indexed readback.
// Optional FRAME_MINMAX_EN adds per-channel min/max outputs (ch_min/ch_max) latched at frame completion.
module frame_sample_buffer #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned NCH   = 2,
    parameter int unsigned CIRC  = 0,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NCH*DW-1:0] idata,
    input  logic              idata_valid,
    input  logic              frame_ack,
    input  logic              rd_en,
    input  logic [CW-1:0]     rd_ch,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     proc_data,
    output logic              proc_valid,
    output logic              fflag,
    output logic [AW:0]       wcount,
    output logic              ovf
`ifdef FRAME_MINMAX_EN
    ,
    output logic [NCH*DW-1:0] ch_min,
    output logic [NCH*DW-1:0] ch_max
`endif
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LASTCNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] LASTPTR = AW'(DEPTH - 1);
    localparam logic [CW:0]   NCH_W   = (CW+1)'(NCH);

    typedef enum logic {FILL, FULL} state_t;
    state_t state;

    logic [DW-1:0] mem [NCH][DEPTH];
    logic [AW-1:0] wptr;

    logic [AW:0]   sum;
    logic [AW-1:0] paddr;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] wptr_nx;
    logic [AW:0]   wbase;
    logic [DW-1:0] rdata;
    logic          in_range;
    logic          filling;
    logic          wr_en;
    logic          frame_done;

    // Address and write-acceptance decode; an ack in the same cycle restarts the frame at address 0
    always_comb begin
        sum = {1'b0, wptr} + {1'b0, raddr};
        if (sum >= DEPTH_W) sum = sum - DEPTH_W;
        paddr      = ((CIRC != 0) && (wcount == DEPTH_W)) ? sum[AW-1:0] : raddr;
        in_range   = ({1'b0, raddr} < wcount) && ({1'b0, rd_ch} < NCH_W);
        wbase      = frame_ack ? '0 : wcount;
        filling    = frame_ack || (state == FILL);
        wr_addr    = frame_ack ? '0 : wptr;
        wptr_nx    = (wr_addr == LASTPTR) ? '0 : wr_addr + AW'(1);
        wr_en      = idata_valid && !Rst && (filling || (CIRC != 0));
        frame_done = wr_en && filling && (wbase == LASTCNT);
    end

    always_comb begin
        rdata = '0;
        for (int unsigned c = 0; c < NCH; c++)
            if (rd_ch == CW'(c)) rdata = mem[c][paddr];
    end

    always_ff @(posedge Clk) begin
        if (wr_en)
            for (int unsigned c = 0; c < NCH; c++)
                mem[c][wr_addr] <= idata[c*DW +: DW];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= FILL;
            wptr       <= '0;
            wcount     <= '0;
            fflag      <= 1'b0;
            ovf        <= 1'b0;
            proc_data  <= '0;
            proc_valid <= 1'b0;
        end else begin
            proc_valid <= rd_en;
            if (rd_en) proc_data <= in_range ? rdata : '0;
            if (frame_ack) begin
                state  <= FILL;
                fflag  <= 1'b0;
                ovf    <= 1'b0;
                wcount <= '0;
                wptr   <= '0;
            end
            if (wr_en) begin
                wptr <= wptr_nx;
                if (filling) wcount <= wbase + (AW+1)'(1);
            end else if (idata_valid && !filling) begin
                ovf <= 1'b1;
            end
            if (frame_done) begin
                state <= FULL;
                fflag <= 1'b1;
            end
        end
    end

`ifdef FRAME_MINMAX_EN
    logic [NCH*DW-1:0] run_min, run_max, min_nx, max_nx;
    logic              mm_first;

    // Running extremes including the current sample; the first write of a fill reseeds them
    always_comb begin
        min_nx = run_min;
        max_nx = run_max;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (mm_first || frame_ack || (idata[c*DW +: DW] < run_min[c*DW +: DW]))
                min_nx[c*DW +: DW] = idata[c*DW +: DW];
            if (mm_first || frame_ack || (idata[c*DW +: DW] > run_max[c*DW +: DW]))
                max_nx[c*DW +: DW] = idata[c*DW +: DW];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mm_first <= 1'b1;
            run_min  <= '1;
            run_max  <= '0;
            ch_min   <= '1;
            ch_max   <= '0;
        end else if (wr_en) begin
            mm_first <= 1'b0;
            run_min  <= min_nx;
            run_max  <= max_nx;
            if (frame_done || !filling) begin
                ch_min <= min_nx;
                ch_max <= max_nx;
            end
        end else if (frame_ack) begin
            mm_first <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_sample_buffer.sv
// Bench for frame_sample_buffer: three instances (hold/128x2, circular/8x2, hold/4x3) against a logical-order frame model.
module tb_frame_sample_buffer;

    localparam int NI = 3;

    function automatic int dep(input int i);
        return (i == 0) ? 128 : (i == 1) ? 8 : 4;
    endfunction
    function automatic int nch(input int i);
        return (i == 2) ? 3 : 2;
    endfunction
    function automatic bit circ(input int i);
        return i == 1;
    endfunction

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst;
    logic       iv [NI];
    logic       ia [NI];
    logic       re [NI];
    logic [1:0] rc [NI];
    logic [6:0] ra [NI];
    logic [7:0] smp [NI][3];

    logic [7:0] pd [NI];
    logic       pv [NI];
    logic       ff [NI];
    logic       ov [NI];
    logic [7:0] wc [NI];
    logic [7:0] wc0;
    logic [3:0] wc1;
    logic [2:0] wc2;
    assign wc[0] = wc0;
    assign wc[1] = 8'(wc1);
    assign wc[2] = 8'(wc2);

`ifdef FRAME_MINMAX_EN
    logic [15:0] mn0, mx0, mn1, mx1;
    logic [23:0] mn2, mx2;
    logic [23:0] mn [NI];
    logic [23:0] mx [NI];
    assign mn[0] = 24'(mn0);
    assign mx[0] = 24'(mx0);
    assign mn[1] = 24'(mn1);
    assign mx[1] = 24'(mx1);
    assign mn[2] = mn2;
    assign mx[2] = mx2;
`endif

    frame_sample_buffer #(.DW(8), .DEPTH(128), .NCH(2), .CIRC(0)) u_hold (
        .Clk(Clk), .Rst(Rst), .idata({smp[0][1], smp[0][0]}), .idata_valid(iv[0]),
        .frame_ack(ia[0]), .rd_en(re[0]), .rd_ch(rc[0][0]), .raddr(ra[0][6:0]),
        .proc_data(pd[0]), .proc_valid(pv[0]), .fflag(ff[0]), .wcount(wc0), .ovf(ov[0])
`ifdef FRAME_MINMAX_EN
        , .ch_min(mn0), .ch_max(mx0)
`endif
    );

    frame_sample_buffer #(.DW(8), .DEPTH(8), .NCH(2), .CIRC(1)) u_circ (
        .Clk(Clk), .Rst(Rst), .idata({smp[1][1], smp[1][0]}), .idata_valid(iv[1]),
        .frame_ack(ia[1]), .rd_en(re[1]), .rd_ch(rc[1][0]), .raddr(ra[1][2:0]),
        .proc_data(pd[1]), .proc_valid(pv[1]), .fflag(ff[1]), .wcount(wc1), .ovf(ov[1])
`ifdef FRAME_MINMAX_EN
        , .ch_min(mn1), .ch_max(mx1)
`endif
    );

    frame_sample_buffer #(.DW(8), .DEPTH(4), .NCH(3), .CIRC(0)) u_small (
        .Clk(Clk), .Rst(Rst), .idata({smp[2][2], smp[2][1], smp[2][0]}), .idata_valid(iv[2]),
        .frame_ack(ia[2]), .rd_en(re[2]), .rd_ch(rc[2]), .raddr(ra[2][1:0]),
        .proc_data(pd[2]), .proc_valid(pv[2]), .fflag(ff[2]), .wcount(wc2), .ovf(ov[2])
`ifdef FRAME_MINMAX_EN
        , .ch_min(mn2), .ch_max(mx2)
`endif
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each frame kept as an oldest-first sample list per channel
    int md [NI][4][128];
    int mcnt [NI];
    bit movf [NI];
    int epd [NI];
    bit epv [NI];
    int rmin [NI][3];
    int rmax [NI][3];
    bit rfirst [NI];
    int emn [NI][3];
    int emx [NI][3];

    always @(posedge Clk) begin
        for (int i = 0; i < NI; i++) begin
            if (Rst) begin
                mcnt[i] = 0; movf[i] = 0; epd[i] = 0; epv[i] = 0; rfirst[i] = 1;
                for (int c = 0; c < 3; c++) begin emn[i][c] = 255; emx[i][c] = 0; end
            end else begin
                bit acc;
                if (re[i]) begin
                    epv[i] = 1;
                    epd[i] = (int'(ra[i]) < mcnt[i] && int'(rc[i]) < nch(i)) ? md[i][rc[i]][ra[i]] : 0;
                end else epv[i] = 0;
                if (ia[i]) begin mcnt[i] = 0; movf[i] = 0; rfirst[i] = 1; end
                if (iv[i]) begin
                    acc = 1;
                    if (mcnt[i] < dep(i)) begin
                        for (int c = 0; c < nch(i); c++) md[i][c][mcnt[i]] = int'(smp[i][c]);
                        mcnt[i]++;
                    end else if (circ(i)) begin
                        for (int c = 0; c < nch(i); c++) begin
                            for (int k = 0; k < dep(i) - 1; k++) md[i][c][k] = md[i][c][k+1];
                            md[i][c][dep(i)-1] = int'(smp[i][c]);
                        end
                    end else begin
                        movf[i] = 1; acc = 0;
                    end
                    if (acc) begin
                        for (int c = 0; c < nch(i); c++) begin
                            if (rfirst[i] || int'(smp[i][c]) < rmin[i][c]) rmin[i][c] = int'(smp[i][c]);
                            if (rfirst[i] || int'(smp[i][c]) > rmax[i][c]) rmax[i][c] = int'(smp[i][c]);
                            if (mcnt[i] == dep(i)) begin emn[i][c] = rmin[i][c]; emx[i][c] = rmax[i][c]; end
                        end
                        rfirst[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("pv%0d", i), 32'(pv[i]), 32'(epv[i]));
                chk($sformatf("pd%0d", i), 32'(pd[i]), 32'(epd[i]));
                chk($sformatf("fflag%0d", i), 32'(ff[i]), 32'(mcnt[i] == dep(i)));
                chk($sformatf("wcount%0d", i), 32'(wc[i]), 32'(mcnt[i]));
                chk($sformatf("ovf%0d", i), 32'(ov[i]), 32'(movf[i]));
`ifdef FRAME_MINMAX_EN
                for (int c = 0; c < nch(i); c++) begin
                    chk($sformatf("chmin%0d_%0d", i, c), 32'(mn[i][c*8 +: 8]), 32'(emn[i][c]));
                    chk($sformatf("chmax%0d_%0d", i, c), 32'(mx[i][c*8 +: 8]), 32'(emx[i][c]));
                end
`endif
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int i, input int s0, input int s1, input int s2);
        iv[i] = 1'b1;
        smp[i][0] = 8'(s0); smp[i][1] = 8'(s1); smp[i][2] = 8'(s2);
        step();
        iv[i] = 1'b0;
    endtask

    task automatic rd(input int i, input int ch, input int a);
        re[i] = 1'b1; rc[i] = 2'(ch); ra[i] = 7'(a);
        step();
        re[i] = 1'b0;
    endtask

    task automatic ack(input int i);
        ia[i] = 1'b1;
        step();
        ia[i] = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 0; ia[i] = 0; re[i] = 0; rc[i] = '0; ra[i] = '0;
            for (int c = 0; c < 3; c++) smp[i][c] = '0;
        end
        repeat (2) step();
        Rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_fflag", 32'(ff[0]), 0);
        chk("rst_wcount", 32'(wc[0]), 0);

        // Hold fill of 128 samples
        for (int k = 0; k < 128; k++) begin
            wr(0, 255 - k, k, 0);
            if (k == 126) chk("t1_fflag_early", 32'(ff[0]), 0);
        end
        chk("t1_fflag", 32'(ff[0]), 1);
        chk("t1_wcount", 32'(wc[0]), 128);
        rd(0, 0, 5);
        chk("t1_rd_ch0", 32'(pd[0]), 250);
        chk("t1_rd_pv", 32'(pv[0]), 1);
        rd(0, 1, 5);
        chk("t1_rd_ch1", 32'(pd[0]), 5);

        // Overflow while full, then ack
        for (int k = 0; k < 3; k++) wr(0, 9, 9, 0);
        chk("t2_ovf", 32'(ov[0]), 1);
        chk("t2_wcount", 32'(wc[0]), 128);
        rd(0, 0, 0);
        chk("t2_addr0", 32'(pd[0]), 255);
        ack(0);
        chk("t2_ack_fflag", 32'(ff[0]), 0);
        chk("t2_ack_ovf", 32'(ov[0]), 0);
        chk("t2_ack_wcount", 32'(wc[0]), 0);

        // Circular mode, 10 writes into depth 8
        for (int v = 1; v <= 10; v++) begin
            wr(1, v, v + 100, 0);
            if (v == 7) chk("t3_fflag_early", 32'(ff[1]), 0);
            if (v == 8) chk("t3_fflag", 32'(ff[1]), 1);
        end
        rd(1, 0, 0);
        chk("t3_raddr0", 32'(pd[1]), 3);
        rd(1, 0, 7);
        chk("t3_raddr7", 32'(pd[1]), 10);
        chk("t3_wcount", 32'(wc[1]), 8);
        rd(1, 1, 7);
        chk("t3_ch1", 32'(pd[1]), 110);
        // Read of the oldest slot while it is being overwritten returns the old sample
        iv[1] = 1; smp[1][0] = 8'd11; smp[1][1] = 8'd111;
        re[1] = 1; rc[1] = 2'd0; ra[1] = 7'd0;
        step();
        iv[1] = 0; re[1] = 0;
        chk("t3_rw_old", 32'(pd[1]), 3);
        rd(1, 0, 0);
        chk("t3_wrap_oldest", 32'(pd[1]), 4);
        rd(1, 0, 7);
        chk("t3_wrap_newest", 32'(pd[1]), 11);

        // Ack and write in the same cycle while full
        ia[1] = 1; iv[1] = 1; smp[1][0] = 8'h5A; smp[1][1] = 8'h5A;
        step();
        ia[1] = 0; iv[1] = 0;
        chk("t4_wcount", 32'(wc[1]), 1);
        chk("t4_fflag", 32'(ff[1]), 0);
        rd(1, 0, 0);
        chk("t4_addr0", 32'(pd[1]), 32'h5A);

        // Out-of-range read and synchronous reset mid-fill
        for (int k = 0; k < 4; k++) wr(0, 11 + k, 21 + k, 0);
        rd(0, 0, 10);
        chk("t5_range_pd", 32'(pd[0]), 0);
        chk("t5_range_pv", 32'(pv[0]), 1);
        rd(0, 1, 3);
        chk("t5_rd_last", 32'(pd[0]), 24);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("t5_rst_pd", 32'(pd[0]), 0);
        chk("t5_rst_pv", 32'(pv[0]), 0);
        chk("t5_rst_fflag", 32'(ff[0]), 0);
        chk("t5_rst_wcount", 32'(wc[0]), 0);
        chk("t5_rst_ovf", 32'(ov[0]), 0);
        wr(0, 8'h77, 8'h88, 0);
        rd(0, 0, 0);
        chk("t5_post_rst_addr0", 32'(pd[0]), 32'h77);

        // Channel index beyond NCH reads as zero
        wr(2, 9, 8, 7);
        rd(2, 3, 0);
        chk("t5_bad_ch_pd", 32'(pd[2]), 0);
        chk("t5_bad_ch_pv", 32'(pv[2]), 1);
        rd(2, 2, 0);
        chk("t5_ch2", 32'(pd[2]), 7);

        // Min/max over a depth-4 frame
        ack(2);
        wr(2, 7, 50, 1);
        wr(2, 200, 60, 1);
        wr(2, 3, 40, 1);
        wr(2, 90, 70, 1);
        chk("t6_fflag", 32'(ff[2]), 1);
`ifdef FRAME_MINMAX_EN
        chk("t6_min_ch0", 32'(mn2[7:0]), 3);
        chk("t6_max_ch0", 32'(mx2[7:0]), 200);
        chk("t6_min_ch1", 32'(mn2[15:8]), 40);
        chk("t6_max_ch1", 32'(mx2[15:8]), 70);
`endif
        wr(2, 1, 1, 1);
        chk("t6_ovf", 32'(ov[2]), 1);
        rd(2, 0, 3);
        chk("t6_rd_last", 32'(pd[2]), 90);

        // More circular traffic for the model to track
        for (int v = 0; v < 12; v++) wr(1, 30 + v, 60 + v, 0);
        for (int a = 0; a < 8; a++) rd(1, a % 2, a);
        step();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
